// File: rtl/rst_seq_sync.sv
// rst_seq_sync: multi-channel reset synchroniser with staggered release; define RST_SEQ_CNT_EN to build the sequence counter
module rst_seq_sync #(
  parameter int NUM_STAGES  = 2,
  parameter int NUM_CH      = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGGER     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sw_rst_req,
  output logic [NUM_CH-1:0] sync_rst,
  output logic              rst_done,
  output logic [7:0]        rst_cnt
);
  localparam int MAXC = HOLD_CYCLES > STAGGER ? HOLD_CYCLES : STAGGER;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [1:0] S_HOLD    = 2'd0;
  localparam logic [1:0] S_STAGGER = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  if (NUM_STAGES < 2 || NUM_STAGES > 8) begin : g_bad_stages
    $error("rst_seq_sync: NUM_STAGES must be 2..8");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
    $error("rst_seq_sync: NUM_CH must be 1..16");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("rst_seq_sync: HOLD_CYCLES must be >= 1");
  end
  if (STAGGER < 1) begin : g_bad_stagger
    $error("rst_seq_sync: STAGGER must be >= 1");
  end
  logic [NUM_STAGES-1:0] chain;
  logic                  rst_s;
  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [NUM_CH-1:0]     nxt_rst;
  logic                  step;
  logic                  done_set;
  assign rst_s = chain[NUM_STAGES-1];
  // next release pattern shifts one more set bit in from channel 0; step fires when the current wait expires
  always_comb begin
    nxt_rst  = (sync_rst << 1) | NUM_CH'(1);
    step     = rst_s && !sw_rst_req &&
               (state == S_HOLD ? cnt == CW'(HOLD_CYCLES - 1) :
                state == S_STAGGER && cnt == CW'(STAGGER - 1));
    done_set = step && nxt_rst[NUM_CH-1];
  end
  // synchroniser chain plus hold/stagger sequencer; software request overrides any progress on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain    <= '0;
      sync_rst <= '0;
      rst_done <= 1'b0;
      state    <= S_HOLD;
      cnt      <= '0;
    end else begin
      chain <= {chain[NUM_STAGES-2:0], 1'b1};
      if (rst_s && sw_rst_req) begin
        sync_rst <= '0;
        rst_done <= 1'b0;
        state    <= S_HOLD;
        cnt      <= '0;
      end else if (step) begin
        sync_rst <= nxt_rst;
        rst_done <= done_set;
        state    <= done_set ? S_DONE : S_STAGGER;
        cnt      <= '0;
      end else if (rst_s && state != S_DONE) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
`ifdef RST_SEQ_CNT_EN
  // counts completed sequences, saturating; only the async reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_cnt <= 8'h00;
    else if (done_set && rst_cnt != 8'hff) rst_cnt <= rst_cnt + 8'h01;
  end
`else
  assign rst_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_rst_seq_sync.sv
// tb_rst_seq_sync: directed bench for rst_seq_sync with default parameters
module tb_rst_seq_sync;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [2:0] sync_rst;
  logic       rst_done;
  logic [7:0] rst_cnt;
  int         errors = 0;
  int         checks = 0;
  int         seqs = 0;
  rst_seq_sync dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw_rst_req(sw_rst_req),
    .sync_rst(sync_rst),
    .rst_done(rst_done),
    .rst_cnt(rst_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [2:0] therm(int e, int t0);
    return {e >= t0 + 4, e >= t0 + 2, e >= t0};
  endfunction
  function automatic logic [7:0] exp_cnt();
`ifdef RST_SEQ_CNT_EN
    return seqs > 255 ? 8'hff : 8'(seqs);
`else
    return 8'h00;
`endif
  endfunction
  task automatic run_release(input string name, input int t0, input int n);
    for (int e = 1; e <= n; e++) begin
      tick();
      checks++;
      if (sync_rst !== therm(e, t0) || rst_done !== (e >= t0 + 4)) begin
        errors++;
        $display("FAIL %s edge %0d: sync_rst=%b rst_done=%b expected %b %b", name, e, sync_rst, rst_done, therm(e, t0), e >= t0 + 4);
      end
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (sync_rst !== 3'b000 || rst_done !== 1'b0 || rst_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset: sync_rst=%b rst_done=%b rst_cnt=%0d expected 000 0 0", sync_rst, rst_done, rst_cnt);
    end
  endtask
  task automatic test_power_on();
    rst_n = 1'b1;
    run_release("power_on", 6, 12);
    seqs++;
    checks++;
    if (rst_cnt !== exp_cnt()) begin
      errors++;
      $display("FAIL power_on_cnt: rst_cnt=%0d expected %0d", rst_cnt, exp_cnt());
    end
  endtask
  task automatic test_async_assert();
    #3 rst_n = 1'b0;
    #1;
    seqs = 0;
    checks++;
    if (sync_rst !== 3'b000 || rst_done !== 1'b0 || rst_cnt !== 8'h00) begin
      errors++;
      $display("FAIL async_assert: sync_rst=%b rst_done=%b rst_cnt=%0d expected 000 0 0", sync_rst, rst_done, rst_cnt);
    end
    tick();
    tick();
    rst_n = 1'b1;
    run_release("re_release", 6, 12);
    seqs++;
  endtask
  task automatic test_sw_single();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    checks++;
    if (sync_rst !== 3'b000 || rst_done !== 1'b0) begin
      errors++;
      $display("FAIL sw_single_clear: sync_rst=%b rst_done=%b expected 000 0", sync_rst, rst_done);
    end
    run_release("sw_single", 4, 10);
    seqs++;
    checks++;
    if (rst_cnt !== exp_cnt()) begin
      errors++;
      $display("FAIL sw_single_cnt: rst_cnt=%0d expected %0d", rst_cnt, exp_cnt());
    end
  endtask
  task automatic test_sw_held();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    run_release("sw_held_pre", 4, 4);
    sw_rst_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (sync_rst !== 3'b000 || rst_done !== 1'b0) begin
        errors++;
        $display("FAIL sw_held cycle %0d: sync_rst=%b rst_done=%b expected 000 0", i, sync_rst, rst_done);
      end
    end
    sw_rst_req = 1'b0;
    run_release("sw_held_post", 4, 10);
    seqs++;
  endtask
  task automatic test_sw_ignored();
    rst_n = 1'b0;
    sw_rst_req = 1'b1;
    tick();
    tick();
    seqs = 0;
    checks++;
    if (sync_rst !== 3'b000 || rst_done !== 1'b0) begin
      errors++;
      $display("FAIL sw_ignored_in_reset: sync_rst=%b rst_done=%b expected 000 0", sync_rst, rst_done);
    end
    rst_n = 1'b1;
    run_release("sw_ignored_chain", 6, 2);
    sw_rst_req = 1'b0;
    for (int e = 3; e <= 12; e++) begin
      tick();
      checks++;
      if (sync_rst !== therm(e, 6) || rst_done !== (e >= 10)) begin
        errors++;
        $display("FAIL sw_ignored edge %0d: sync_rst=%b rst_done=%b expected %b %b", e, sync_rst, rst_done, therm(e, 6), e >= 10);
      end
    end
    seqs++;
  endtask
  task automatic do_sw_seq();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    repeat (9) tick();
    seqs++;
  endtask
  task automatic test_cnt();
    rst_n = 1'b0;
    tick();
    seqs = 0;
    checks++;
    if (rst_cnt !== 8'h00) begin
      errors++;
      $display("FAIL cnt_clear: rst_cnt=%0d expected 0", rst_cnt);
    end
    rst_n = 1'b1;
    repeat (12) tick();
    seqs++;
    repeat (3) do_sw_seq();
    checks++;
    if (rst_cnt !== exp_cnt() || rst_done !== 1'b1) begin
      errors++;
      $display("FAIL cnt_after_3_sw: rst_cnt=%0d rst_done=%b expected %0d 1", rst_cnt, rst_done, exp_cnt());
    end
    repeat (296) do_sw_seq();
    checks++;
    if (rst_cnt !== exp_cnt() || rst_done !== 1'b1) begin
      errors++;
      $display("FAIL cnt_saturate: rst_cnt=%0d rst_done=%b expected %0d 1", rst_cnt, rst_done, exp_cnt());
    end
  endtask
  initial begin
    test_reset();
    test_power_on();
    test_async_assert();
    test_sw_single();
    test_sw_held();
    test_sw_ignored();
    test_cnt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
